// File: rtl/matmul_tile_sched.sv
// Handshaked (i, j, k) tile sequencer for the blocked matrix multiplier.
// Issues one calc job at a time and hands each finished output tile to writeback.
module matmul_tile_sched #(
    parameter int TILES_I = 2,
    parameter int TILES_J = 2,
    parameter int TILES_K = 2,
    localparam int IW = (TILES_I > 1) ? $clog2(TILES_I) : 1,
    localparam int JW = (TILES_J > 1) ? $clog2(TILES_J) : 1,
    localparam int KW = (TILES_K > 1) ? $clog2(TILES_K) : 1,
    localparam int CW = $clog2(TILES_I * TILES_J * TILES_K + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic          calc_done,
    input  logic          wb_done,
    output logic          busy,
    output logic          tile_start,
    output logic          acc_clear,
    output logic          acc_last,
    output logic [IW-1:0] tile_i,
    output logic [JW-1:0] tile_j,
    output logic [KW-1:0] tile_k,
    output logic          wb_start,
    output logic          done,
    output logic [CW-1:0] jobs_issued
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_CALC,
        ISSUE_WB,
        WAIT_WB,
        FINISH
    } state_t;

    localparam logic [IW-1:0] I_LAST = IW'(TILES_I - 1);
    localparam logic [JW-1:0] J_LAST = JW'(TILES_J - 1);
    localparam logic [KW-1:0] K_LAST = KW'(TILES_K - 1);

    state_t        state;
    state_t        state_next;
    logic [IW-1:0] i_next;
    logic [JW-1:0] j_next;
    logic [KW-1:0] k_next;
    logic [CW-1:0] jobs_next;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            tile_i      <= '0;
            tile_j      <= '0;
            tile_k      <= '0;
            jobs_issued <= '0;
        end else begin
            state       <= state_next;
            tile_i      <= i_next;
            tile_j      <= j_next;
            tile_k      <= k_next;
            jobs_issued <= jobs_next;
        end
    end

    always_comb begin
        state_next = state;
        i_next     = tile_i;
        j_next     = tile_j;
        k_next     = tile_k;
        jobs_next  = jobs_issued;
        case (state)
            IDLE: begin
                i_next = '0;
                j_next = '0;
                k_next = '0;
                // An abort in the same cycle keeps the previous run's job count visible.
                if (start && !abort) begin
                    jobs_next  = '0;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                jobs_next  = jobs_issued + CW'(1);
                state_next = WAIT_CALC;
            end
            WAIT_CALC: begin
                if (calc_done) begin
                    if (tile_k != K_LAST) begin
                        k_next     = tile_k + KW'(1);
                        state_next = ISSUE;
                    end else begin
                        state_next = ISSUE_WB;
                    end
                end
            end
            ISSUE_WB: state_next = WAIT_WB;
            WAIT_WB: begin
                if (wb_done) begin
                    if (tile_i == I_LAST && tile_j == J_LAST) begin
                        state_next = FINISH;
                    end else begin
                        k_next = '0;
                        if (tile_j == J_LAST) begin
                            j_next = '0;
                            i_next = tile_i + IW'(1);
                        end else begin
                            j_next = tile_j + JW'(1);
                        end
                        state_next = ISSUE;
                    end
                end
            end
            FINISH: begin
                i_next     = '0;
                j_next     = '0;
                k_next     = '0;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (abort) begin
            state_next = IDLE;
            i_next     = '0;
            j_next     = '0;
            k_next     = '0;
        end
    end

    // Every output is a decode of registered state, so no input reaches an output combinationally.
    assign busy       = (state != IDLE);
    assign tile_start = (state == ISSUE);
    assign acc_clear  = (state == ISSUE) && (tile_k == '0);
    assign acc_last   = (state == ISSUE) && (tile_k == K_LAST);
    assign wb_start   = (state == ISSUE_WB);
    assign done       = (state == FINISH);

endmodule

// File: tb/tb_matmul_tile_sched.sv
// Directed bench for matmul_tile_sched: a 2x2x2 instance for ordering, spurious
// pulses, abort and async reset, and a 1x1x1 instance for exact cycle timing.
module tb_matmul_tile_sched;

    logic       clock;
    logic       reset;
    logic       start, abort, calc_done, wb_done;
    logic       busy, tile_start, acc_clear, acc_last, wb_start, done;
    logic       tile_i, tile_j, tile_k;
    logic [3:0] jobs_issued;

    logic       start_1, abort_1, calc_done_1, wb_done_1;
    logic       busy_1, tile_start_1, acc_clear_1, acc_last_1, wb_start_1, done_1;
    logic       tile_i_1, tile_j_1, tile_k_1;
    logic       jobs_issued_1;

    int total = 0;
    int bad   = 0;

    logic [4:0] exp_q[$];
    logic [1:0] wb_q[$];

    matmul_tile_sched #(.TILES_I(2), .TILES_J(2), .TILES_K(2)) dut (
        .clock(clock), .reset(reset), .start(start), .abort(abort),
        .calc_done(calc_done), .wb_done(wb_done), .busy(busy),
        .tile_start(tile_start), .acc_clear(acc_clear), .acc_last(acc_last),
        .tile_i(tile_i), .tile_j(tile_j), .tile_k(tile_k),
        .wb_start(wb_start), .done(done), .jobs_issued(jobs_issued)
    );

    matmul_tile_sched #(.TILES_I(1), .TILES_J(1), .TILES_K(1)) dut_1 (
        .clock(clock), .reset(reset), .start(start_1), .abort(abort_1),
        .calc_done(calc_done_1), .wb_done(wb_done_1), .busy(busy_1),
        .tile_start(tile_start_1), .acc_clear(acc_clear_1), .acc_last(acc_last_1),
        .tile_i(tile_i_1), .tile_j(tile_j_1), .tile_k(tile_k_1),
        .wb_start(wb_start_1), .done(done_1), .jobs_issued(jobs_issued_1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic load_expected();
        exp_q.delete();
        wb_q.delete();
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                for (int k = 0; k < 2; k++) begin
                    exp_q.push_back({i[0], j[0], k[0], (k == 0), (k == 1)});
                end
                wb_q.push_back({i[0], j[0]});
            end
        end
    endtask

    // mode: 0 plain run, 1 spurious pulses, 2 abort at job (1,0,1), 3 reset in first WAIT_WB
    task automatic run(input int mode, input int calc_lat, input int wb_lat);
        int ccnt, wcnt, cyc, njobs, ndone, nwb, abort_cyc, done_cyc;
        bit stop, wb_prev, abort_pend;
        logic [4:0] e;
        logic [1:0] w;
        ccnt = 0; wcnt = 0; cyc = 0; njobs = 0; ndone = 0; nwb = 0;
        abort_cyc = -1; done_cyc = -1;
        stop = 0; wb_prev = 0; abort_pend = 0;
        load_expected();
        @(negedge clock);
        start = 1'b1;
        while (!stop && cyc < 300) begin
            @(negedge clock);
            cyc++;
            start = 1'b0; calc_done = 1'b0; wb_done = 1'b0; abort = 1'b0;
            if (abort_pend) begin
                abort = 1'b1;
                abort_pend = 0;
                abort_cyc = cyc;
            end
            if (wb_prev) begin
                wb_prev = 0;
                if (mode == 1) begin
                    start = 1'b1;
                    calc_done = 1'b1;
                end
                if (mode == 3) begin
                    reset = 1'b0;
                    #1;
                    check("rst_async_ctl", 32'({busy, tile_start, acc_clear, acc_last, wb_start, done}), 0);
                    check("rst_async_idx", 32'({tile_i, tile_j, tile_k}), 0);
                    check("rst_async_jobs", 32'(jobs_issued), 0);
                    stop = 1;
                end
            end
            if (!stop) begin
                if (ccnt > 0) begin
                    ccnt--;
                    if (ccnt == 0) calc_done = 1'b1;
                end
                if (wcnt > 0) begin
                    wcnt--;
                    if (wcnt == 0) wb_done = 1'b1;
                end
                if (tile_start) begin
                    if (exp_q.size() == 0) begin
                        check("extra_job", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("job_idx", 32'({tile_i, tile_j, tile_k, acc_clear, acc_last}), 32'(e));
                    end
                    check("jobs_at_start", 32'(jobs_issued), njobs);
                    njobs++;
                    ccnt = calc_lat;
                    if (mode == 1 && njobs == 3) begin
                        start = 1'b1; calc_done = 1'b1; wb_done = 1'b1;
                    end
                    if (mode == 2 && njobs == 6) abort_pend = 1;
                end
                if (wb_start) begin
                    if (wb_q.size() == 0) begin
                        check("extra_wb", 1, 0);
                    end else begin
                        w = wb_q.pop_front();
                        check("wb_idx", 32'({tile_i, tile_j}), 32'(w));
                    end
                    nwb++;
                    wcnt = wb_lat;
                    wb_prev = 1;
                end
                if (done) begin
                    ndone++;
                    if (done_cyc < 0) begin
                        done_cyc = cyc;
                        check("done_jobs", 32'(jobs_issued), 8);
                        check("done_jobs_left", exp_q.size(), 0);
                        check("done_wb_left", wb_q.size(), 0);
                    end
                end
                if (abort_cyc >= 0 && cyc == abort_cyc + 1) begin
                    check("abort_busy", 32'(busy), 0);
                    check("abort_idx", 32'({tile_i, tile_j, tile_k}), 0);
                    check("abort_jobs", 32'(jobs_issued), 6);
                    ccnt = 0;
                end
                if (done_cyc >= 0 && cyc == done_cyc + 1) check("busy_after_done", 32'(busy), 0);
                if (done_cyc >= 0 && cyc > done_cyc + 1)
                    check("no_rerun", 32'({busy, tile_start}), 0);
                if (abort_cyc >= 0 && cyc == abort_cyc + 6) begin
                    check("abort_jobs_held", 32'(jobs_issued), 6);
                    stop = 1;
                end
                if (done_cyc >= 0 && cyc == done_cyc + 6) stop = 1;
            end
        end
        start = 1'b0; calc_done = 1'b0; wb_done = 1'b0; abort = 1'b0;
        if (!stop) check("timeout", 0, 1);
        if (mode == 2) begin
            check("abort_no_done", ndone, 0);
            check("abort_wb_count", nwb, 2);
        end else if (mode != 3) begin
            check("done_count", ndone, 1);
            check("wb_count", nwb, 4);
            check("job_count", njobs, 8);
        end
    endtask

    task automatic run_single();
        @(negedge clock);
        start_1 = 1'b1;
        @(negedge clock);
        start_1 = 1'b0;
        check("s1_c1", 32'({busy_1, tile_start_1, acc_clear_1, acc_last_1, wb_start_1, done_1}), 32'b111100);
        @(negedge clock);
        check("s1_c2", 32'({busy_1, tile_start_1, wb_start_1, done_1}), 32'b1000);
        calc_done_1 = 1'b1;
        @(negedge clock);
        calc_done_1 = 1'b0;
        check("s1_c3", 32'({busy_1, tile_start_1, wb_start_1, done_1}), 32'b1010);
        @(negedge clock);
        check("s1_c4", 32'({busy_1, wb_start_1, done_1}), 32'b100);
        wb_done_1 = 1'b1;
        @(negedge clock);
        wb_done_1 = 1'b0;
        check("s1_c5", 32'({busy_1, wb_start_1, done_1}), 32'b101);
        check("s1_jobs", 32'(jobs_issued_1), 1);
        @(negedge clock);
        check("s1_c6", 32'({busy_1, done_1}), 32'b00);
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0; abort = 1'b0; calc_done = 1'b0; wb_done = 1'b0;
        start_1 = 1'b0; abort_1 = 1'b0; calc_done_1 = 1'b0; wb_done_1 = 1'b0;
        @(negedge clock);
        check("reset_ctl", 32'({busy, tile_start, acc_clear, acc_last, wb_start, done}), 0);
        check("reset_idx", 32'({tile_i, tile_j, tile_k, jobs_issued}), 0);
        reset = 1'b1;
        @(negedge clock);
        check("idle_hold", 32'({busy, tile_start}), 0);

        run_single();
        run(0, 3, 2);
        run(1, 3, 2);
        run(2, 3, 2);

        @(negedge clock);
        start = 1'b1; abort = 1'b1;
        @(negedge clock);
        start = 1'b0; abort = 1'b0;
        check("abort_beats_start", 32'(busy), 0);
        check("abort_start_jobs", 32'(jobs_issued), 6);

        run(0, 3, 2);
        run(3, 3, 2);
        @(negedge clock);
        reset = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(negedge clock);
            check("post_reset_idle", 32'({busy, tile_start, wb_start, done}), 0);
        end
        run(0, 1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
